// File: rtl/risk_score_mac.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | risk_score_mac: three-stage weighted-sum risk scorer with saturation       |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module risk_score_mac #(
   parameter int              N_CH     = 4,
   parameter int              DW       = 8,
   parameter int              WW       = 8,
   parameter int              OW       = 8,
   parameter int              SHIFT    = 0,
   parameter logic [N_CH-1:0] UNS_MASK = N_CH'(4'b1000),
   localparam int             C_PW     = DW + WW + 1,
   localparam int             C_CW     = $clog2(N_CH),
   localparam int             C_SW     = C_PW + C_CW + 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   input  logic [N_CH*DW-1:0]   in_data,
   input  logic                 wr_en,
   input  logic [4:0]           wr_addr,
   input  logic [C_PW-1:0]      wr_data,
   input  logic                 sat_clr,
   output logic                 out_valid,
   output logic [OW-1:0]        score,
   output logic                 sat_hi,
   output logic                 sat_lo,
   output logic [15:0]          sat_cnt
);

   logic [WW-1:0]       w_q    [N_CH];
   logic [C_PW-1:0]     bias_q;
   logic [C_PW-1:0]     prod_d [N_CH];
   logic [C_PW-1:0]     prod_q [N_CH];
   logic                v1_q;
   logic [C_SW-1:0]     sum_d;
   logic [C_SW-1:0]     sum_q;
   logic                v2_q;
   logic signed [C_SW-1:0] t_d;
   logic                hi_d;
   logic                lo_d;
   logic [OW-1:0]       score_d;
   logic [OW-1:0]       score_q;
   logic                ov_q;
   logic                hi_q;
   logic                lo_q;
   logic [15:0]         cnt_q;

   // Configuration registers; a same-cycle sample still sees the old value.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < N_CH; i++) begin
            w_q[i] <= '0;
         end
         bias_q <= '0;
      end else if (wr_en) begin
         for (int i = 0; i < N_CH; i++) begin
            if (wr_addr == 5'(i)) begin
               w_q[i] <= wr_data[WW-1:0];
            end
         end
         if (wr_addr == 5'd31) begin
            bias_q <= wr_data;
         end
      end
   end

   for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      logic [DW-1:0]   x;
      logic [C_PW-1:0] x_ext;
      logic [C_PW-1:0] w_ext;

      assign x      = in_data[gi*DW +: DW];
      assign x_ext  = UNS_MASK[gi] ? {{(C_PW-DW){1'b0}}, x}
                                   : {{(C_PW-DW){x[DW-1]}}, x};
      assign w_ext  = {{(C_PW-WW){w_q[gi][WW-1]}}, w_q[gi]};
      // Both operands fit the product width, so the low C_PW bits are exact.
      assign prod_d[gi] = $signed(x_ext) * $signed(w_ext);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < N_CH; i++) begin
            prod_q[i] <= '0;
         end
         v1_q <= 1'b0;
      end else begin
         v1_q <= in_valid;
         if (in_valid) begin
            for (int i = 0; i < N_CH; i++) begin
               prod_q[i] <= prod_d[i];
            end
         end
      end
   end

   always_comb begin
      sum_d = {{(C_SW-C_PW){bias_q[C_PW-1]}}, bias_q};
      for (int i = 0; i < N_CH; i++) begin
         sum_d = sum_d + {{(C_SW-C_PW){prod_q[i][C_PW-1]}}, prod_q[i]};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sum_q <= '0;
         v2_q  <= 1'b0;
      end else begin
         v2_q <= v1_q;
         if (v1_q) begin
            sum_q <= sum_d;
         end
      end
   end

   // Clip to the unsigned score range; exact 0 and all-ones are not clipped.
   assign t_d  = $signed(sum_q) >>> SHIFT;
   assign lo_d = t_d[C_SW-1];
   assign hi_d = !t_d[C_SW-1] && (t_d[C_SW-2:OW] != '0);

   always_comb begin
      score_d = t_d[OW-1:0];
      if (lo_d) begin
         score_d = '0;
      end else if (hi_d) begin
         score_d = '1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         score_q <= '0;
         ov_q    <= 1'b0;
         hi_q    <= 1'b0;
         lo_q    <= 1'b0;
      end else begin
         ov_q <= v2_q;
         hi_q <= v2_q & hi_d;
         lo_q <= v2_q & lo_d;
         if (v2_q) begin
            score_q <= score_d;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else if (sat_clr) begin
         cnt_q <= '0;
      end else if (v2_q && (hi_d || lo_d) && (cnt_q != 16'hFFFF)) begin
         cnt_q <= cnt_q + 16'd1;
      end
   end

   assign out_valid = ov_q;
   assign score     = score_q;
   assign sat_hi    = hi_q;
   assign sat_lo    = lo_q;
   assign sat_cnt   = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_risk_score_mac.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_risk_score_mac: directed and randomized checks of risk_score_mac        |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_risk_score_mac;

   localparam logic [3:0] UNS = 4'b1000;

   logic        clk      = 1'b0;
   logic        rst      = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] in_data  = '0;
   logic        wr_en    = 1'b0;
   logic [4:0]  wr_addr  = '0;
   logic [16:0] wr_data  = '0;
   logic        sat_clr  = 1'b0;
   logic        out_valid;
   logic [7:0]  score;
   logic        sat_hi;
   logic        sat_lo;
   logic [15:0] sat_cnt;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int mw [4];
   int mb       = 0;

   typedef struct {
      int due;
      int sc;
      bit hi;
      bit lo;
   } exp_t;

   risk_score_mac dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .sat_clr   (sat_clr),
      .out_valid (out_valid),
      .score     (score),
      .sat_hi    (sat_hi),
      .sat_lo    (sat_lo),
      .sat_cnt   (sat_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Reference: score = clamp((bias + sum w*x) >>> 0, 0, 255)
   function automatic void model(input logic [31:0] d, output int sc, output bit hi, output bit lo);
      int s;
      s = mb;
      for (int i = 0; i < 4; i++) begin
         logic [7:0] b;
         int x;
         b = d[i*8 +: 8];
         x = UNS[i] ? int'(b) : int'($signed(b));
         s = s + mw[i] * x;
      end
      hi = 1'b0;
      lo = 1'b0;
      if (s < 0) begin
         sc = 0;
         lo = 1'b1;
      end else if (s > 255) begin
         sc = 255;
         hi = 1'b1;
      end else begin
         sc = s;
      end
   endfunction

   task automatic wr(input logic [4:0] a, input int v);
      wr_en   = 1'b1;
      wr_addr = a;
      wr_data = v[16:0];
      step();
      wr_en   = 1'b0;
      if (a < 5'd4) mw[a] = int'($signed(v[7:0]));
      else if (a == 5'd31) mb = int'($signed(v[16:0]));
   endtask

   task automatic send(input logic [31:0] d);
      in_valid = 1'b1;
      in_data  = d;
      step();
      in_valid = 1'b0;
      step();
      step();
   endtask

   task automatic test_reset();
      rst = 1'b0;
      step();
      step();
      n_checks++;
      if ({out_valid, sat_hi, sat_lo, score, sat_cnt} !== 27'd0) begin
         n_fail++;
         $display("FAIL reset_state: got %h expected 0", {out_valid, sat_hi, sat_lo, score, sat_cnt});
      end
      rst      = 1'b1;
      in_valid = 1'b1;
      in_data  = $urandom;
      step();
      in_valid = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_lat1: out_valid got %b expected 0", out_valid);
      end
      step();
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_lat2: out_valid got %b expected 0", out_valid);
      end
      step();
      n_checks++;
      if ({out_valid, sat_hi, sat_lo, score, sat_cnt} !== {1'b1, 1'b0, 1'b0, 8'd0, 16'd0}) begin
         n_fail++;
         $display("FAIL reset_first_sample: got %h expected %h",
                  {out_valid, sat_hi, sat_lo, score, sat_cnt}, {1'b1, 1'b0, 1'b0, 8'd0, 16'd0});
      end
   endtask

   task automatic test_nominal();
      wr(5'd0, 2);
      wr(5'd1, 1);
      wr(5'd2, 3);
      wr(5'd3, 1);
      wr(5'd31, 0);
      in_valid = 1'b1;
      in_data  = {8'd20, 8'd5, 8'hFC, 8'd10};
      step();
      in_valid = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL nominal_lat1: out_valid got %b expected 0", out_valid);
      end
      step();
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL nominal_lat2: out_valid got %b expected 0", out_valid);
      end
      step();
      n_checks++;
      if ({out_valid, sat_hi, sat_lo, score} !== {1'b1, 1'b0, 1'b0, 8'd51}) begin
         n_fail++;
         $display("FAIL nominal_score: got %h expected %h", {out_valid, sat_hi, sat_lo, score},
                  {1'b1, 1'b0, 1'b0, 8'd51});
      end
      step();
      n_checks++;
      if ({out_valid, score} !== {1'b0, 8'd51}) begin
         n_fail++;
         $display("FAIL nominal_hold: got %h expected %h", {out_valid, score}, {1'b0, 8'd51});
      end
   endtask

   task automatic test_clip();
      wr(5'd0, -10);
      wr(5'd1, 0);
      wr(5'd2, 0);
      wr(5'd3, 0);
      send(32'd100);
      n_checks++;
      if ({out_valid, sat_hi, sat_lo, score, sat_cnt} !== {1'b1, 1'b0, 1'b1, 8'd0, 16'd1}) begin
         n_fail++;
         $display("FAIL clip_low: got %h expected %h", {out_valid, sat_hi, sat_lo, score, sat_cnt},
                  {1'b1, 1'b0, 1'b1, 8'd0, 16'd1});
      end
      wr(5'd0, 0);
      wr(5'd3, 127);
      send(32'hFF00_0000);
      n_checks++;
      if ({out_valid, sat_hi, sat_lo, score, sat_cnt} !== {1'b1, 1'b1, 1'b0, 8'd255, 16'd2}) begin
         n_fail++;
         $display("FAIL clip_high: got %h expected %h", {out_valid, sat_hi, sat_lo, score, sat_cnt},
                  {1'b1, 1'b1, 1'b0, 8'd255, 16'd2});
      end
      wr(5'd3, 1);
      send(32'hFF00_0000);
      n_checks++;
      if ({out_valid, sat_hi, sat_lo, score, sat_cnt} !== {1'b1, 1'b0, 1'b0, 8'd255, 16'd2}) begin
         n_fail++;
         $display("FAIL edge_255: got %h expected %h", {out_valid, sat_hi, sat_lo, score, sat_cnt},
                  {1'b1, 1'b0, 1'b0, 8'd255, 16'd2});
      end
      send(32'd0);
      n_checks++;
      if ({out_valid, sat_hi, sat_lo, score, sat_cnt} !== {1'b1, 1'b0, 1'b0, 8'd0, 16'd2}) begin
         n_fail++;
         $display("FAIL edge_0: got %h expected %h", {out_valid, sat_hi, sat_lo, score, sat_cnt},
                  {1'b1, 1'b0, 1'b0, 8'd0, 16'd2});
      end
      wr(5'd31, 1);
      send(32'hFF00_0000);
      n_checks++;
      if ({out_valid, sat_hi, sat_lo, score, sat_cnt} !== {1'b1, 1'b1, 1'b0, 8'd255, 16'd3}) begin
         n_fail++;
         $display("FAIL edge_256: got %h expected %h", {out_valid, sat_hi, sat_lo, score, sat_cnt},
                  {1'b1, 1'b1, 1'b0, 8'd255, 16'd3});
      end
      wr(5'd31, -1);
      send(32'd0);
      n_checks++;
      if ({out_valid, sat_hi, sat_lo, score, sat_cnt} !== {1'b1, 1'b0, 1'b1, 8'd0, 16'd4}) begin
         n_fail++;
         $display("FAIL edge_m1: got %h expected %h", {out_valid, sat_hi, sat_lo, score, sat_cnt},
                  {1'b1, 1'b0, 1'b1, 8'd0, 16'd4});
      end
      wr(5'd31, 0);
   endtask

   task automatic test_collision();
      wr(5'd0, 1);
      wr(5'd3, 0);
      wr_en    = 1'b1;
      wr_addr  = 5'd0;
      wr_data  = 17'd5;
      in_valid = 1'b1;
      in_data  = 32'd10;
      step();
      wr_en    = 1'b0;
      mw[0]    = 5;
      step();
      in_valid = 1'b0;
      step();
      n_checks++;
      if ({out_valid, score} !== {1'b1, 8'd10}) begin
         n_fail++;
         $display("FAIL collision_old: got %h expected %h", {out_valid, score}, {1'b1, 8'd10});
      end
      step();
      n_checks++;
      if ({out_valid, score} !== {1'b1, 8'd50}) begin
         n_fail++;
         $display("FAIL collision_new: got %h expected %h", {out_valid, score}, {1'b1, 8'd50});
      end
      step();
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL collision_end: out_valid got %b expected 0", out_valid);
      end
   endtask

   task automatic test_back_to_back();
      int es [3];
      bit eh [3];
      bit el [3];
      logic [31:0] d;
      for (int i = 0; i < 4; i++) wr(5'(i), int'($urandom_range(0, 6)) - 3);
      wr(5'd31, int'($urandom_range(0, 200)) - 50);
      for (int k = 0; k < 3; k++) begin
         d = $urandom;
         model(d, es[k], eh[k], el[k]);
         in_valid = 1'b1;
         in_data  = d;
         step();
         if (k < 2) begin
            n_checks++;
            if (out_valid !== 1'b0) begin
               n_fail++;
               $display("FAIL b2b_early%0d: out_valid got %b expected 0", k, out_valid);
            end
         end
      end
      in_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         n_checks++;
         if ({out_valid, sat_hi, sat_lo, score} !== {1'b1, eh[k], el[k], 8'(es[k])}) begin
            n_fail++;
            $display("FAIL b2b_out%0d: got %h expected %h", k, {out_valid, sat_hi, sat_lo, score},
                     {1'b1, eh[k], el[k], 8'(es[k])});
         end
         step();
      end
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_end: out_valid got %b expected 0", out_valid);
      end
   endtask

   task automatic test_satclr();
      wr(5'd0, -10);
      wr(5'd1, 0);
      wr(5'd2, 0);
      wr(5'd3, 0);
      wr(5'd31, 0);
      sat_clr = 1'b1;
      step();
      sat_clr = 1'b0;
      n_checks++;
      if (sat_cnt !== 16'd0) begin
         n_fail++;
         $display("FAIL satclr_idle: sat_cnt got %0d expected 0", sat_cnt);
      end
      send(32'd100);
      n_checks++;
      if ({out_valid, sat_lo, sat_cnt} !== {1'b1, 1'b1, 16'd1}) begin
         n_fail++;
         $display("FAIL satclr_count: got %h expected %h", {out_valid, sat_lo, sat_cnt}, {1'b1, 1'b1, 16'd1});
      end
      in_valid = 1'b1;
      in_data  = 32'd100;
      step();
      in_valid = 1'b0;
      step();
      sat_clr = 1'b1;
      step();
      sat_clr = 1'b0;
      n_checks++;
      if ({out_valid, sat_lo, sat_cnt} !== {1'b1, 1'b1, 16'd0}) begin
         n_fail++;
         $display("FAIL satclr_priority: got %h expected %h", {out_valid, sat_lo, sat_cnt}, {1'b1, 1'b1, 16'd0});
      end
   endtask

   task automatic test_random();
      exp_t q [$];
      exp_t e;
      int   exp_cnt = 0;
      int   last_sc = 0;
      bit   seen    = 1'b0;
      sat_clr = 1'b1;
      step();
      sat_clr = 1'b0;
      for (int n = 0; n < 80; n++) begin
         bit          v;
         bit          we;
         bit          clr;
         bit          exiting;
         logic [31:0] d;
         logic [4:0]  a;
         int          r;
         int          wv;
         exp_t        ne;
         v   = (n < 77) && ($urandom_range(0, 3) != 0);
         clr = (n < 77) && ($urandom_range(0, 9) == 0);
         d   = $urandom;
         r   = int'($urandom_range(0, 7));
         we  = (n < 77) && (r < 6);
         a   = (r < 4) ? 5'(r) : (r == 4) ? 5'd31 : 5'($urandom_range(4, 30));
         if (a == 5'd31) begin
            wv = int'($urandom_range(0, 600)) - 300;
         end else begin
            wv = int'($urandom & 32'h1FFFF);
            if ($urandom_range(0, 1) == 1) wv = (wv & ~255) | ((int'($urandom_range(0, 8)) - 4) & 255);
         end
         if (v) begin
            model(d, ne.sc, ne.hi, ne.lo);
            ne.due = cyc + 3;
            q.push_back(ne);
         end
         if (we) begin
            if (a < 5'd4) mw[a] = int'($signed(wv[7:0]));
            else if (a == 5'd31) mb = int'($signed(wv[16:0]));
         end
         in_valid = v;
         in_data  = d;
         wr_en    = we;
         wr_addr  = a;
         wr_data  = wv[16:0];
         sat_clr  = clr;
         exiting  = (q.size() > 0) && (q[0].due == cyc + 1);
         step();
         in_valid = 1'b0;
         wr_en    = 1'b0;
         sat_clr  = 1'b0;
         if (exiting) begin
            e = q.pop_front();
            n_checks++;
            if ({out_valid, sat_hi, sat_lo, score} !== {1'b1, e.hi, e.lo, 8'(e.sc)}) begin
               n_fail++;
               $display("FAIL rand_out c%0d: got %h expected %h", cyc, {out_valid, sat_hi, sat_lo, score},
                        {1'b1, e.hi, e.lo, 8'(e.sc)});
            end
            if (clr) exp_cnt = 0;
            else if ((e.hi || e.lo) && exp_cnt < 65535) exp_cnt++;
            last_sc = e.sc;
            seen    = 1'b1;
         end else begin
            n_checks++;
            if ({out_valid, sat_hi, sat_lo} !== 3'b000) begin
               n_fail++;
               $display("FAIL rand_idle c%0d: got %b expected 000", cyc, {out_valid, sat_hi, sat_lo});
            end
            if (seen) begin
               n_checks++;
               if (score !== 8'(last_sc)) begin
                  n_fail++;
                  $display("FAIL rand_hold c%0d: score got %0d expected %0d", cyc, score, last_sc);
               end
            end
            if (clr) exp_cnt = 0;
         end
         n_checks++;
         if (sat_cnt !== 16'(exp_cnt)) begin
            n_fail++;
            $display("FAIL rand_cnt c%0d: sat_cnt got %0d expected %0d", cyc, sat_cnt, exp_cnt);
         end
      end
      n_checks++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL rand_drain: %0d samples outstanding expected 0", q.size());
      end
   endtask

   task automatic test_reset_midflight();
      wr(5'd0, 1);
      wr(5'd31, 3);
      in_valid = 1'b1;
      in_data  = 32'd5;
      step();
      in_data  = 32'd6;
      step();
      in_valid = 1'b0;
      rst      = 1'b0;
      #1;
      n_checks++;
      if ({out_valid, sat_cnt} !== 17'd0) begin
         n_fail++;
         $display("FAIL midrst_async: got %h expected 0", {out_valid, sat_cnt});
      end
      step();
      rst = 1'b1;
      for (int i = 0; i < 4; i++) mw[i] = 0;
      mb = 0;
      for (int k = 0; k < 5; k++) begin
         step();
         n_checks++;
         if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_quiet%0d: out_valid got %b expected 0", k, out_valid);
         end
      end
      send($urandom);
      n_checks++;
      if ({out_valid, sat_hi, sat_lo, score, sat_cnt} !== {1'b1, 1'b0, 1'b0, 8'd0, 16'd0}) begin
         n_fail++;
         $display("FAIL midrst_zero: got %h expected %h", {out_valid, sat_hi, sat_lo, score, sat_cnt},
                  {1'b1, 1'b0, 1'b0, 8'd0, 16'd0});
      end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_clip();
      test_collision();
      test_back_to_back();
      test_satclr();
      test_random();
      test_reset_midflight();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
